// File: rtl/water_pkg.sv
// water_pkg: controller state encoding and default timing constants,
// shared between water_dispenser and water_valve_controller.
package water_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_DISPENSING, ST_FAULT} state_t;
    localparam int DEF_PULSES_PER_UNIT = 4;
    localparam int DEF_TIMEOUT_CYCLES  = 1000;
endpackage

// File: rtl/water_valve_if.sv
// water_valve_if: amount hand-off and status bundle between water_dispenser
// (master) and water_valve_controller (slave).
interface water_valve_if #(parameter int AMOUNT_WIDTH = 32);
    logic                    start;
    logic [AMOUNT_WIDTH-1:0] amount;
    logic                    busy;
    logic                    done;
    logic                    aborted;
    logic                    fault;
    logic [AMOUNT_WIDTH-1:0] remaining;
    logic [AMOUNT_WIDTH-1:0] dispensed;
    modport master (output start, amount, input busy, done, aborted, fault, remaining, dispensed);
    modport slave  (input start, amount, output busy, done, aborted, fault, remaining, dispensed);
endinterface

// File: rtl/input_synchronizer.sv
// input_synchronizer: two-flop synchronizer for an asynchronous pin, plus a
// third flop for rise/fall edge detection on the synchronized level.
module input_synchronizer #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_pin,
    output logic o_rise,
    output logic o_fall
);
    logic [2:0] r_sync;
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) r_sync <= {3{RESET_VAL}};
        else            r_sync <= {r_sync[1:0], i_pin};
    end
    assign o_rise = r_sync[1] & ~r_sync[2];
    assign o_fall = ~r_sync[1] & r_sync[2];
endmodule

// File: rtl/water_valve_controller.sv
// water_valve_controller: opens the valve for a latched amount and counts
// flow-meter pulses down to zero, with stop-button abort and stall watchdog.
module water_valve_controller
    import water_pkg::*;
#(
    parameter int AMOUNT_WIDTH    = 32,
    parameter int PULSES_PER_UNIT = DEF_PULSES_PER_UNIT,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    input  logic          i_flow_pulse,
    input  logic          i_button_stop,
    output logic          o_valve_open,
    water_valve_if.slave  bus
);
    localparam int SW = $clog2(PULSES_PER_UNIT + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SUB_LAST = SW'(PULSES_PER_UNIT - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [AMOUNT_WIDTH-1:0] REM_ONE = {{(AMOUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                  r_state, w_next;
    logic [AMOUNT_WIDTH-1:0] r_remaining, w_remaining, r_dispensed, w_dispensed;
    logic [SW-1:0]           r_sub, w_sub;
    logic [WW-1:0]           r_wdog, w_wdog;
    logic                    r_done, w_done, r_aborted, w_aborted;
    logic                    w_flow, w_stop, w_unit, w_finish, w_expire;

    input_synchronizer #(.RESET_VAL(1'b0)) u_flow_sync (
        .i_clock(i_clock), .i_reset_n(i_reset_n), .i_pin(i_flow_pulse),
        .o_rise(w_flow), .o_fall()
    );
    input_synchronizer #(.RESET_VAL(1'b1)) u_stop_sync (
        .i_clock(i_clock), .i_reset_n(i_reset_n), .i_pin(i_button_stop),
        .o_rise(), .o_fall(w_stop)
    );

    // A flow edge on the expiry cycle rescues the job, so expiry needs no flow.
    assign w_unit   = w_flow && r_sub == SUB_LAST && r_remaining != '0;
    assign w_finish = w_unit && r_remaining == REM_ONE;
    assign w_expire = !w_flow && r_wdog == WD_LAST;

    always_comb begin
        w_next      = r_state;
        w_remaining = r_remaining;
        w_dispensed = r_dispensed;
        w_sub       = r_sub;
        w_wdog      = r_wdog;
        w_done      = 1'b0;
        w_aborted   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_done      = bus.amount == '0;
                    w_next      = bus.amount == '0 ? ST_IDLE : ST_DISPENSING;
                    w_remaining = bus.amount;
                    w_dispensed = '0;
                    w_sub       = '0;
                    w_wdog      = '0;
                end
            end
            ST_DISPENSING: begin
                w_sub       = w_flow ? (r_sub == SUB_LAST ? '0 : r_sub + 1'b1) : r_sub;
                w_wdog      = w_flow ? '0 : r_wdog + 1'b1;
                w_remaining = w_unit ? r_remaining - 1'b1 : r_remaining;
                w_dispensed = w_unit ? r_dispensed + 1'b1 : r_dispensed;
                w_next      = (w_finish || w_stop) ? ST_IDLE : w_expire ? ST_FAULT : ST_DISPENSING;
                w_done      = w_finish;
                w_aborted   = !w_finish && w_stop;
            end
            ST_FAULT: begin
                w_next      = w_stop ? ST_IDLE : ST_FAULT;
                w_remaining = w_stop ? '0 : r_remaining;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_dispensed <= '0;
            r_sub       <= '0;
            r_wdog      <= '0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_remaining <= w_remaining;
            r_dispensed <= w_dispensed;
            r_sub       <= w_sub;
            r_wdog      <= w_wdog;
            r_done      <= w_done;
            r_aborted   <= w_aborted;
        end
    end

    // Outputs decode the state register directly so async reset closes the valve at once.
    assign o_valve_open  = r_state == ST_DISPENSING;
    assign bus.busy      = r_state == ST_DISPENSING;
    assign bus.fault     = r_state == ST_FAULT;
    assign bus.done      = r_done;
    assign bus.aborted   = r_aborted;
    assign bus.remaining = r_remaining;
    assign bus.dispensed = r_dispensed;
endmodule

// File: tb/tb_water_valve_controller.sv
// tb_water_valve_controller: directed checks of job, zero, abort, stall,
// collision and async-reset behaviour with PULSES_PER_UNIT=4, TIMEOUT_CYCLES=50.
module tb_water_valve_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flow = 1'b0;
    logic stop = 1'b1;
    logic valve;
    int   n_checks = 0;
    int   n_fail = 0;

    water_valve_if #(.AMOUNT_WIDTH(32)) bus ();

    water_valve_controller #(
        .AMOUNT_WIDTH(32), .PULSES_PER_UNIT(4), .TIMEOUT_CYCLES(50)
    ) dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_flow_pulse(flow),
        .i_button_stop(stop), .o_valve_open(valve), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse();
        flow = 1'b1;
        tick(3);
        flow = 1'b0;
        tick(3);
    endtask

    task automatic launch(input logic [31:0] amt);
        bus.amount = amt;
        bus.start  = 1'b1;
        tick(1);
        bus.start  = 1'b0;
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.amount = '0;
        #20;
        chk_b("rst_valve", valve, 1'b0);
        chk_b("rst_busy", bus.busy, 1'b0);
        chk_b("rst_done", bus.done, 1'b0);
        chk_b("rst_fault", bus.fault, 1'b0);
        chk_w("rst_remaining", bus.remaining, 32'd0);
        #2 rst_n = 1'b1;
        tick(2);

        // Normal job: 3 units, 12 flow edges
        launch(32'd3);
        chk_b("job_busy", bus.busy, 1'b1);
        chk_b("job_valve", valve, 1'b1);
        chk_w("job_rem0", bus.remaining, 32'd3);
        for (int k = 1; k <= 12; k++) begin
            flow = 1'b1;
            tick(3);
            chk_w($sformatf("job_rem_e%0d", k), bus.remaining, 32'(3 - k / 4));
            if (k < 12) begin
                chk_b($sformatf("job_valve_e%0d", k), valve, 1'b1);
                chk_b($sformatf("job_nodone_e%0d", k), bus.done, 1'b0);
            end else begin
                chk_b("job_done", bus.done, 1'b1);
                chk_b("job_valve_closed", valve, 1'b0);
                chk_w("job_dispensed", bus.dispensed, 32'd3);
            end
            flow = 1'b0;
            tick(3);
        end
        chk_b("job_done_one_cycle", bus.done, 1'b0);

        // Zero amount
        launch(32'd0);
        chk_b("zero_done", bus.done, 1'b1);
        chk_b("zero_valve", valve, 1'b0);
        chk_b("zero_busy", bus.busy, 1'b0);
        chk_w("zero_dispensed", bus.dispensed, 32'd0);
        tick(1);
        chk_b("zero_done_end", bus.done, 1'b0);
        chk_b("zero_valve_end", valve, 1'b0);

        // Abort after 9 flow edges of a 22-unit job
        launch(32'd22);
        repeat (9) pulse();
        stop = 1'b0;
        tick(2);
        chk_b("abort_not_yet", bus.aborted, 1'b0);
        chk_b("abort_busy_still", bus.busy, 1'b1);
        tick(1);
        chk_b("abort_pulse", bus.aborted, 1'b1);
        chk_b("abort_valve", valve, 1'b0);
        chk_b("abort_busy", bus.busy, 1'b0);
        chk_b("abort_nodone", bus.done, 1'b0);
        chk_w("abort_remaining", bus.remaining, 32'd20);
        chk_w("abort_dispensed", bus.dispensed, 32'd2);
        tick(1);
        chk_b("abort_pulse_end", bus.aborted, 1'b0);
        tick(1);
        stop = 1'b1;
        tick(3);

        // Stall into FAULT
        launch(32'd5);
        tick(49);
        chk_b("stall_nofault_49", bus.fault, 1'b0);
        chk_b("stall_valve_49", valve, 1'b1);
        tick(1);
        chk_b("stall_fault", bus.fault, 1'b1);
        chk_b("stall_valve", valve, 1'b0);
        chk_b("stall_busy", bus.busy, 1'b0);
        launch(32'd9);
        chk_b("fault_start_ignored", bus.fault, 1'b1);
        chk_w("fault_remaining", bus.remaining, 32'd5);
        chk_b("fault_start_nobusy", bus.busy, 1'b0);
        stop = 1'b0;
        tick(3);
        chk_b("fault_cleared", bus.fault, 1'b0);
        chk_b("fault_clear_noabort", bus.aborted, 1'b0);
        chk_w("fault_rem_cleared", bus.remaining, 32'd0);
        chk_w("fault_disp_held", bus.dispensed, 32'd0);
        stop = 1'b1;
        tick(3);

        // Collision: final edge and stop press in the same event cycle
        launch(32'd1);
        pulse();
        launch(32'd9);
        chk_w("busy_start_remaining", bus.remaining, 32'd1);
        chk_b("busy_start_busy", bus.busy, 1'b1);
        pulse();
        pulse();
        flow = 1'b1;
        stop = 1'b0;
        tick(3);
        chk_b("coll_done", bus.done, 1'b1);
        chk_b("coll_noabort", bus.aborted, 1'b0);
        chk_w("coll_remaining", bus.remaining, 32'd0);
        chk_w("coll_dispensed", bus.dispensed, 32'd1);
        tick(1);
        chk_b("coll_idle_noabort", bus.aborted, 1'b0);
        flow = 1'b0;
        stop = 1'b1;
        tick(3);

        // Async reset in the middle of a job
        launch(32'd7);
        chk_w("ar_remaining", bus.remaining, 32'd7);
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        chk_b("ar_valve", valve, 1'b0);
        chk_b("ar_busy", bus.busy, 1'b0);
        chk_w("ar_remaining0", bus.remaining, 32'd0);
        chk_b("ar_nodone", bus.done, 1'b0);
        chk_b("ar_noabort", bus.aborted, 1'b0);
        #3 rst_n = 1'b1;
        tick(2);
        chk_b("ar_idle_valve", valve, 1'b0);
        chk_b("ar_idle_done", bus.done, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
